// File: rtl/pe_rs_if.sv
// pe_rs_if: stream bundle for pe_rs (weight/ifmap/psum_in in, psum_out and busy out); master = feeder, slave = PE
interface pe_rs_if #(
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32
);
  logic              w_valid, w_ready;
  logic [DATA_W-1:0] w_data;
  logic              ifmap_valid, ifmap_ready, ifmap_last, keep_w;
  logic [DATA_W-1:0] ifmap_data;
  logic              psum_in_valid, psum_in_ready;
  logic [PSUM_W-1:0] psum_in_data;
  logic              psum_out_valid, psum_out_ready;
  logic [PSUM_W-1:0] psum_out_data;
  logic              busy;
  modport master (
    output w_valid, w_data, ifmap_valid, ifmap_data, ifmap_last, keep_w,
           psum_in_valid, psum_in_data, psum_out_ready,
    input  w_ready, ifmap_ready, psum_in_ready, psum_out_valid, psum_out_data, busy
  );
  modport slave (
    input  w_valid, w_data, ifmap_valid, ifmap_data, ifmap_last, keep_w,
           psum_in_valid, psum_in_data, psum_out_ready,
    output w_ready, ifmap_ready, psum_in_ready, psum_out_valid, psum_out_data, busy
  );
endinterface

// File: rtl/pe_rs.sv
// pe_rs: row-stationary PE (clk, async active-low rst, bus: weight/ifmap/psum_in streams in, psum_out stream and busy out)
module pe_rs #(
  parameter int DATA_W   = 16,
  parameter int PSUM_W   = 32,
  parameter int FILT_LEN = 3,
  parameter bit SIGNED   = 1
) (
  input  logic  clk,
  input  logic  rst,
  pe_rs_if.slave bus
);
  localparam int CW = $clog2(FILT_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);
  typedef enum logic [2:0] {LOAD_W, FILL, MAC, ACC, OUT, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] w_q [FILT_LEN];
  logic [DATA_W-1:0] w_d [FILT_LEN];
  logic [DATA_W-1:0] x_q [FILT_LEN];
  logic [DATA_W-1:0] x_d [FILT_LEN];
  logic [DATA_W-1:0] x_sh [FILT_LEN];
  logic [DATA_W-1:0] wk, xk;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [PSUM_W-1:0] acc_q, acc_d, out_q, out_d, prod;
  logic              last_q, last_d;
  assign bus.w_ready        = state_q == LOAD_W;
  assign bus.ifmap_ready    = state_q == FILL || state_q == SHIFT;
  assign bus.psum_in_ready  = state_q == ACC;
  assign bus.psum_out_valid = state_q == OUT;
  assign bus.psum_out_data  = out_q;
  assign bus.busy           = state_q != LOAD_W;
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    last_d  = last_q;
    cnt_inc = cnt_q == LAST ? '0 : cnt_q + CW'(1);
    wk      = w_q[cnt_q];
    xk      = x_q[cnt_q];
    // operands extended to PSUM_W first, so the wrapped product equals the extended 2*DATA_W product
    prod    = {{(PSUM_W-DATA_W){SIGNED && wk[DATA_W-1]}}, wk} *
              {{(PSUM_W-DATA_W){SIGNED && xk[DATA_W-1]}}, xk};
    for (int i = 0; i < FILT_LEN - 1; i++) x_sh[i] = x_q[i+1];
    x_sh[FILT_LEN-1] = bus.ifmap_data;
    case (state_q)
      LOAD_W: if (bus.w_valid) begin
        w_d[cnt_q] = bus.w_data;
        cnt_d      = cnt_inc;
        state_d    = cnt_q == LAST ? FILL : LOAD_W;
      end
      FILL: if (bus.ifmap_valid) begin
        x_d   = x_sh;
        cnt_d = cnt_inc;
        if (cnt_q == LAST) begin
          acc_d   = '0;
          last_d  = bus.ifmap_last;
          state_d = MAC;
        end else if (bus.ifmap_last) begin
          cnt_d   = '0;
          state_d = bus.keep_w ? FILL : LOAD_W;
        end
      end
      MAC: begin
        acc_d   = acc_q + prod;
        cnt_d   = cnt_inc;
        state_d = cnt_q == LAST ? ACC : MAC;
      end
      ACC: if (bus.psum_in_valid) begin
        out_d   = acc_q + bus.psum_in_data;
        state_d = OUT;
      end
      OUT: if (bus.psum_out_ready) begin
        last_d  = 1'b0;
        state_d = !last_q ? SHIFT : bus.keep_w ? FILL : LOAD_W;
      end
      SHIFT: if (bus.ifmap_valid) begin
        x_d     = x_sh;
        last_d  = bus.ifmap_last;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MAC;
      end
      default: state_d = LOAD_W;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_W;
      w_q     <= '{default: '0};
      x_q     <= '{default: '0};
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_pe_rs.sv
// tb_pe_rs: drives a signed and an unsigned pe_rs in lockstep and checks them against a dot-product model
module tb_pe_rs;
  localparam int S = 3;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic        w_valid = 0, ifmap_valid = 0, ifmap_last = 0, keep_w = 0, psum_in_valid = 0, psum_out_ready = 0;
  logic [15:0] w_data = 0, ifmap_data = 0;
  logic [31:0] psum_in_data = 0;
  pe_rs_if #(.DATA_W(16), .PSUM_W(32)) ifs ();
  pe_rs_if #(.DATA_W(16), .PSUM_W(32)) ifu ();
  assign ifs.w_valid = w_valid;             assign ifu.w_valid = w_valid;
  assign ifs.w_data = w_data;               assign ifu.w_data = w_data;
  assign ifs.ifmap_valid = ifmap_valid;     assign ifu.ifmap_valid = ifmap_valid;
  assign ifs.ifmap_data = ifmap_data;       assign ifu.ifmap_data = ifmap_data;
  assign ifs.ifmap_last = ifmap_last;       assign ifu.ifmap_last = ifmap_last;
  assign ifs.keep_w = keep_w;               assign ifu.keep_w = keep_w;
  assign ifs.psum_in_valid = psum_in_valid; assign ifu.psum_in_valid = psum_in_valid;
  assign ifs.psum_in_data = psum_in_data;   assign ifu.psum_in_data = psum_in_data;
  assign ifs.psum_out_ready = psum_out_ready; assign ifu.psum_out_ready = psum_out_ready;
  pe_rs #(.DATA_W(16), .PSUM_W(32), .FILT_LEN(S), .SIGNED(1)) u_s (.clk(clk), .rst(rst), .bus(ifs));
  pe_rs #(.DATA_W(16), .PSUM_W(32), .FILT_LEN(S), .SIGNED(0)) u_u (.clk(clk), .rst(rst), .bus(ifu));
  int checks = 0, errors = 0;
  logic [15:0] mw [S];
  logic [15:0] mx [16];
  logic [31:0] mp [16];
  logic [31:0] got_s, got_u;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // window p: sum of w[k]*x[p+k] in full precision plus psum, then wrapped to 32 bits
  function automatic logic [31:0] model(input bit sgn, input int p);
    longint acc = longint'(mp[p]);
    longint a, b;
    for (int k = 0; k < S; k++) begin
      a = sgn ? longint'($signed(mw[k])) : longint'(mw[k]);
      b = sgn ? longint'($signed(mx[p+k])) : longint'(mx[p+k]);
      acc += a * b;
    end
    return acc[31:0];
  endfunction
  function automatic logic rdy(input int which);
    return which == 0 ? ifs.w_ready : which == 1 ? ifs.ifmap_ready :
           which == 2 ? ifs.psum_in_ready : ifs.psum_out_valid;
  endfunction
  task automatic wait_for(input int which, input string tag, output int t);
    t = 0;
    while (!rdy(which) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_wait"}, 32'(t < 50), 32'd1);
  endtask
  task automatic send_w(input logic [15:0] v);
    int t;
    w_data = v; w_valid = 1;
    wait_for(0, "w_ready", t);
    @(negedge clk);
    w_valid = 0;
  endtask
  task automatic send_x(input logic [15:0] v, input bit last);
    int t;
    ifmap_data = v; ifmap_last = last; ifmap_valid = 1;
    wait_for(1, "ifmap_ready", t);
    @(negedge clk);
    ifmap_valid = 0; ifmap_last = 0;
  endtask
  task automatic put_psum(input logic [31:0] v, output int t);
    psum_in_data = v; psum_in_valid = 1;
    wait_for(2, "psum_in_ready", t);
    @(negedge clk);
    psum_in_valid = 0;
  endtask
  task automatic get_out(input string tag, input logic [31:0] es, input logic [31:0] eu);
    int t;
    psum_out_ready = 1;
    wait_for(3, {tag, "_valid"}, t);
    got_s = ifs.psum_out_data;
    got_u = ifu.psum_out_data;
    chk({tag, "_s"}, got_s, es);
    chk({tag, "_u"}, got_u, eu);
    @(negedge clk);
    psum_out_ready = 0;
  endtask
  task automatic load_w();
    for (int k = 0; k < S; k++) send_w(mw[k]);
  endtask
  task automatic run_row(input int n, input string tag);
    int t;
    for (int i = 0; i < n && i < S; i++) send_x(mx[i], i == n - 1);
    for (int p = 0; p + S <= n; p++) begin
      if (p > 0) send_x(mx[p+S-1], p + S == n);
      put_psum(mp[p], t);
      chk({tag, "_lat"}, 32'(t), 32'(S));
      get_out($sformatf("%s_out%0d", tag, p), model(1, p), model(0, p));
    end
  endtask
  // {w_ready, busy, ifmap_ready, psum_in_ready, psum_out_valid}
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk({tag, "_flags_s"}, 32'({ifs.w_ready, ifs.busy, ifs.ifmap_ready, ifs.psum_in_ready, ifs.psum_out_valid}), 32'(exp));
    chk({tag, "_flags_u"}, 32'({ifu.w_ready, ifu.busy, ifu.ifmap_ready, ifu.psum_in_ready, ifu.psum_out_valid}), 32'(exp));
  endtask
  task automatic chk_reset(input string tag);
    chk_flags(tag, 5'b10000);
    chk({tag, "_data_s"}, ifs.psum_out_data, 32'd0);
    chk({tag, "_data_u"}, ifu.psum_out_data, 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    bit loaded;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1;
    @(negedge clk);
    chk_reset("post_reset");
    mw = '{16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 5; i++) begin mx[i] = 16'(i + 1); mp[i] = 32'd10; end
    load_w();
    run_row(5, "basic");
    chk("basic_last", got_s, 32'd36);
    chk_flags("basic_idle", 5'b10000);
    mw = '{16'hFFFE, 16'd0, 16'd0};
    mx[0] = 16'd3; mx[1] = 16'd0; mx[2] = 16'd0; mp[0] = 32'd0;
    load_w();
    run_row(3, "sign");
    chk("sign_const_s", got_s, 32'hFFFFFFFA);
    chk("sign_const_u", got_u, 32'h0002FFFA);
    for (int k = 0; k < S; k++) mw[k] = 16'($urandom);
    for (int i = 0; i < 4; i++) mx[i] = 16'($urandom);
    mp[0] = $urandom; mp[1] = $urandom;
    load_w();
    for (int i = 0; i < S; i++) send_x(mx[i], 1'b0);
    wait_for(2, "bp_acc", t);
    repeat (4) begin
      @(negedge clk);
      chk_flags("acc_stall", 5'b01010);
    end
    put_psum(mp[0], t);
    wait_for(3, "bp_out", t);
    repeat (5) begin
      @(negedge clk);
      chk_flags("out_stall", 5'b01001);
      chk("out_stall_data_s", ifs.psum_out_data, model(1, 0));
      chk("out_stall_data_u", ifu.psum_out_data, model(0, 0));
    end
    get_out("bp0", model(1, 0), model(0, 0));
    chk_flags("bp_once", 5'b01100);
    send_x(mx[3], 1'b1);
    put_psum(mp[1], t);
    chk("bp1_lat", 32'(t), 32'(S));
    get_out("bp1", model(1, 1), model(0, 1));
    chk_flags("bp_idle", 5'b10000);
    mw = '{16'd1, 16'd2, 16'd3};
    mx[0] = 16'd1; mx[1] = 16'd1; mx[2] = 16'd1; mp[0] = 32'd0;
    keep_w = 1;
    load_w();
    run_row(3, "reuse");
    chk("reuse_const", got_s, 32'd6);
    chk_flags("reuse_fill", 5'b01100);
    mx[0] = 16'd7; mx[1] = 16'd8;
    run_row(2, "short");
    chk_flags("short_fill", 5'b01100);
    keep_w = 0;
    for (int i = 0; i < 4; i++) begin mx[i] = 16'($urandom); mp[i] = $urandom; end
    run_row(4, "reuse2");
    chk_flags("reuse2_idle", 5'b10000);
    mw = '{16'd1, 16'd0, 16'd0};
    mx[0] = 16'd1; mx[1] = 16'd0; mx[2] = 16'd0; mp[0] = 32'hFFFFFFFF;
    load_w();
    run_row(3, "wrap");
    chk("wrap_const_s", got_s, 32'd0);
    chk("wrap_const_u", got_u, 32'd0);
    loaded = 0;
    for (int r = 0; r < 8; r++) begin
      if (!loaded) begin
        for (int k = 0; k < S; k++) mw[k] = 16'($urandom);
        load_w();
      end
      for (int i = 0; i < 8; i++) begin mx[i] = 16'($urandom); mp[i] = $urandom; end
      keep_w = 1'($urandom_range(0, 1));
      run_row($urandom_range(1, 7), $sformatf("rnd%0d", r));
      chk_flags($sformatf("rnd%0d_end", r), keep_w ? 5'b01100 : 5'b10000);
      loaded = keep_w;
    end
    keep_w = 0;
    if (!loaded) load_w();
    for (int i = 0; i < S; i++) send_x(16'($urandom), 1'b0);
    @(negedge clk);
    chk_flags("mid_mac", 5'b01000);
    rst = 0;
    #1;
    chk_reset("mac_reset");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_reset("mac_release");
    mw = '{16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 5; i++) begin mx[i] = 16'(i + 1); mp[i] = 32'd10; end
    load_w();
    run_row(5, "basic2");
    chk("basic2_last", got_s, 32'd36);
    chk_flags("basic2_idle", 5'b10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_rs.md
# pe_rs

Row-stationary processing element: the parametrised successor to the single-cycle `pe` MAC. It holds a filter row of `FILT_LEN` weights in a local scratchpad and slides a `FILT_LEN`-deep ifmap window along a streamed input row. For each window position it computes one dot product, adds an incoming partial sum and emits the result. All three streams use valid/ready handshakes, so it chains vertically in the PE array: `psum_out` of one PE feeds `psum_in` of the next.

## Interface
- `DATA_W`, 16, width of weight and ifmap values
- `PSUM_W`, 32, width of partial sums; must be ≥ 2*`DATA_W`
- `FILT_LEN`, 3, filter row length S; must be ≥ 2
- `SIGNED`, 1, 1 = two's-complement multiply, 0 = unsigned
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `w_valid` / `w_ready`  in / out  1  weight stream handshake
- `w_data`  in  DATA_W  weight value
- `ifmap_valid` / `ifmap_ready`  in / out  1  ifmap stream handshake
- `ifmap_data`  in  DATA_W  ifmap value
- `ifmap_last`  in  1  marks the final ifmap of the row; sampled with the handshake
- `keep_w`  in  1  sampled at end of row: 1 = reuse weights, 0 = reload
- `psum_in_valid` / `psum_in_ready`  in / out  1  incoming partial sum handshake
- `psum_in_data`  in  PSUM_W  incoming partial sum
- `psum_out_valid` / `psum_out_ready`  out / in  1  result handshake
- `psum_out_data`  out  PSUM_W  result
- `busy`  out  1  high in every state except LOAD_W

## Operation
- A handshake is valid/ready both high at a rising edge. Ready signals decode from the state register only and never depend on the corresponding valid.
- **LOAD_W**
  - `w_ready`=1.
  - The k-th handshake writes w[k], for k=0..S-1.
  - After the S-th handshake, go to FILL.
- **FILL**
  - `ifmap_ready`=1.
  - Each handshake shifts the window: x[i] ← x[i+1], and x[S-1] ← data.
  - After S handshakes, go to MAC with k=0 and acc=0.
  - If `ifmap_last` is accepted before the S-th value, discard the partial window, emit nothing, and go to FILL if `keep_w`=1 or LOAD_W if `keep_w`=0.
- **MAC**
  - Runs for S cycles. Cycle k computes acc ← acc + ext(w[k]·x[k]).
  - After k=S-1, go to ACC.
- **ACC**
  - `psum_in_ready`=1.
  - On handshake, `psum_out_data` ← acc + `psum_in_data`, then go to OUT.
  - Stalls indefinitely if `psum_in_valid` stays low.
- **OUT**
  - `psum_out_valid`=1; `psum_out_data` is held stable.
  - On handshake, if the last flag is set: go to FILL if `keep_w`=1, else LOAD_W, and clear the flag.
  - On handshake with the last flag clear: go to SHIFT.
- **SHIFT**
  - `ifmap_ready`=1.
  - Handshake shifts one value into the window and latches `ifmap_last` into the last flag.
  - Then go to MAC with acc=0.
- The last flag is also set when `ifmap_last` arrives on the S-th FILL handshake; that window is still computed and emitted.
- Arithmetic:
  - The product is 2*`DATA_W` bits, sign- or zero-extended per `SIGNED` to `PSUM_W`.
  - All sums wrap modulo 2^`PSUM_W`.
  - No saturation and no overflow flag.

## Timing
- Reset values:
  - State = LOAD_W, so `w_ready`=1 and `busy`=0.
  - `ifmap_ready`=0, `psum_in_ready`=0, `psum_out_valid`=0, `psum_out_data`=0.
  - acc, w[], x[], counters and the last flag are all 0.
- Reset asserted mid-operation aborts immediately to the reset state. Outstanding outputs and stored weights are lost.
- Latency:
  - From the final FILL or SHIFT handshake to `psum_in_ready`=1: exactly S cycles.
  - From the `psum_in` handshake to `psum_out_valid`=1: the next cycle.
- Steady-state throughput with all streams always valid/ready: one result per S+3 cycles.
- Only one stream is ready in any state, so there are no simultaneous handshakes. Inputs on non-ready streams are ignored.

## Test plan
- **Basic row.** S=3, SIGNED=1.
  - Stimulus: weights 1,2,3; ifmaps 1,2,3,4,5 with last on 5; `psum_in` 10 each time.
  - Required: outputs 24, 30, 36, then state LOAD_W with `busy`=0.
  - Required: first `psum_in_ready` exactly 3 cycles after the 3rd ifmap handshake.
- **Signed vs unsigned.**
  - Stimulus: weights 0xFFFE,0,0; ifmaps 3,0,0 (last); `psum_in` 0.
  - Required: SIGNED=1 gives 0xFFFFFFFA. SIGNED=0 gives 0x0002FFFA.
- **Backpressure and stall.**
  - Hold `psum_out_ready`=0 for 5 cycles: `psum_out_valid` and data stay stable, `ifmap_ready` stays 0, and each result is emitted exactly once.
  - Hold `psum_in_valid`=0 for 4 cycles: ACC waits.
- **Weight reuse and short row.**
  - Row 1 (weights 1,2,3): ifmaps 1,1,1 with last on the 3rd and `keep_w`=1 → single output 6 with `psum_in`=0. Then FILL, with no `w_ready`.
  - Row 2: ifmaps 7,8 with last on 8 → no output. Remain FILL-ready.
- **Wrap-around.**
  - Stimulus: weights 1,0,0; ifmaps 1,0,0; `psum_in`=0xFFFFFFFF.
  - Required: output 0.
- **Reset mid-MAC.**
  - Stimulus: drop `rst` during the 2nd MAC cycle.
  - Required: all outputs return to reset values at once, and `w_ready`=1 after release.
  - Then a full reload reproduces the basic-row results.
